mac_job_scheduler: RTL and testbench
====================================

# mac_job_scheduler

Job-level sequencer between the MAC control register file and the streamer/engine pair. It turns one `start_i` pulse plus latched job registers into `nb_iter` back-to-back iterations. In each iteration it:
- arms the streamer once the streamer reports ready,
- launches the engine,
- waits for the engine result,
- waits for the result store to complete.

It then raises a single done pulse that the control unit turns into a core event.

## Interface
Clock is `clk_i`; reset is `rst_ni`, asynchronous, active-low. One clock domain.

Parameters:
- `CNT_W`, default 16: width of the length and iteration counters.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous soft clear, same effect as reset.
- `start_i` in 1: job trigger pulse from the control unit.
- `len_i` in CNT_W: MACs per iteration; latched at start.
- `nb_iter_i` in CNT_W: number of iterations; latched at start.
- `simple_mul_i` in 1: engine mode; latched at start.
- `stream_ready_i` in 1: all four streamer channels are idle and ready.
- `engine_done_i` in 1: engine output valid pulse (one per iteration).
- `store_done_i` in 1: streamer finished writing the `d` result (pulse).
- `req_start_o` out 1: streamer start pulse, loads `a/b/c` and stores `d` for the current iteration.
- `engine_start_o` out 1: engine start pulse, coincident with `req_start_o`.
- `engine_clear_o` out 1: engine accumulator clear, one pulse per job.
- `engine_len_o` out CNT_W: latched `len`.
- `engine_simple_mul_o` out 1: latched mode.
- `iter_idx_o` out CNT_W: index of the current iteration.
- `busy_o` out 1: a job is in progress.
- `done_o` out 1: job-complete pulse.

## Operation
States:
- `IDLE`: `busy_o=0`.
  - On `start_i` with `len_i!=0` and `nb_iter_i!=0`: latch `len`, `nb_iter` and mode; clear `iter_idx`; go to `CLEAR`.
  - On `start_i` with `len_i==0` or `nb_iter_i==0`: stay in `IDLE`; `done_o` pulses on the next cycle; no streamer or engine activity.
- `CLEAR`: `engine_clear_o=1` for exactly one cycle, then go to `ARM`.
- `ARM`: wait for `stream_ready_i`.
  - `req_start_o = engine_start_o = (state==ARM) & stream_ready_i`. This is the only combinational path.
  - When it fires, clear the `eng_seen` and `st_seen` flags and go to `RUN`.
- `RUN`: sticky flags `eng_seen` and `st_seen` record `engine_done_i` and `store_done_i`.
  - `store_done_i` is counted only in the same cycle as, or after, `engine_done_i`. An earlier `store_done_i` is ignored.
  - Once both flags are set (including both pulses in the same cycle), go to `NEXT`.
- `NEXT`:
  - If `iter_idx==nb_iter-1`, go to `DONE`.
  - Otherwise increment `iter_idx` and go to `ARM`. There is no engine clear between iterations.
- `DONE`: `done_o=1` for one cycle, then go to `IDLE`.

Rules:
- `busy_o=1` in every state except `IDLE`.
- `start_i` while busy is ignored; latched config does not change.
- `clear_i` in any state forces `IDLE`, zeroes all registers, and suppresses `done_o`. `clear_i` has priority over `start_i` in the same cycle.
- Counters are unsigned CNT_W bits. `nb_iter=2^CNT_W-1` must run fully; there is no wrap-around of `iter_idx`.

## Timing
- Reset values: every output is 0, the state is `IDLE`, and all latched registers are 0.
- Start to clear: `start_i` in cycle 0 → `engine_clear_o` in cycle 1 → `ARM` in cycle 2.
- With `stream_ready_i` already high, `req_start_o` fires in cycle 2.
- Per-iteration overhead beyond the streamer and engine latency is 2 cycles: `RUN` exit → `NEXT` → `ARM`.
- The last completion is followed by `done_o` exactly 2 cycles later (`NEXT`, `DONE`). `busy_o` falls in the same cycle `done_o` falls.
- Zero-length job: `start_i` in cycle 0 → `done_o` in cycle 1 only; `busy_o` stays 0 throughout.
- All outputs except `req_start_o` and `engine_start_o` are registered.

## Structure
- `mac_package` holds:
  - `sched_state_t`, the enum `{IDLE, CLEAR, ARM, RUN, NEXT, DONE}`;
  - `ctrl_sched_t`, which packs `len`, `nb_iter` and `simple_mul`;
  - `flags_sched_t`, which packs `busy`, `done` and `iter_idx`.
- One sub-module, `mac_sched_counter`: a CNT_W-bit counter with clear, enable and a terminal-count compare against `nb_iter-1`.

## Test plan
- **Basic job.** `len=8`, `nb_iter=3`, streamer always ready, and the engine and store models pulse 10 cycles after each start.
  - Exactly 3 `req_start_o` pulses and 1 `engine_clear_o` pulse.
  - `iter_idx_o` steps 0→1→2.
  - One `done_o`, 2 cycles after the third `store_done_i`.
- **Zero length.** `len=0`, `nb_iter=5`: `done_o` in cycle 1, no `req_start_o`, `busy_o` never set.
- **Simultaneous completion.** `engine_done_i` and `store_done_i` in the same cycle → `NEXT` on the next cycle.
  - Also drive a premature `store_done_i` before `engine_done_i`: it is ignored, and the scheduler waits for the next `store_done_i`.
- **Streamer backpressure.** Hold `stream_ready_i` low for 20 cycles in `ARM` → no start pulses; `req_start_o` fires in the first cycle `stream_ready_i` is high.
- **Clear mid-job.** `nb_iter=4`; assert `clear_i` during iteration 2 → `IDLE` next cycle, `iter_idx_o=0`, no `done_o`.
  - A fresh `start_i` afterwards runs a full job.
  - Asynchronous `rst_ni` in `RUN` gives the same result.
- **Start while busy.** Pulse `start_i` with `len=1` during a `len=8` job → `engine_len_o` stays 8 and exactly one `done_o` is produced.

Source files
------------

// File: rtl/mac_job_scheduler_pkg.sv
// Shared types for the MAC job scheduler: FSM states, latched job config and status flags.
package mac_package;

  localparam int MAC_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    RUN,
    NEXT,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [MAC_CNT_W-1:0] len;
    logic [MAC_CNT_W-1:0] nb_iter;
    logic                 simple_mul;
  } ctrl_sched_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [MAC_CNT_W-1:0] iter_idx;
  } flags_sched_t;

  // A job with no MACs or no iterations completes immediately without touching the datapath.
  function automatic logic job_is_empty(input logic [MAC_CNT_W-1:0] len,
                                        input logic [MAC_CNT_W-1:0] nb_iter);
    return (len == '0) || (nb_iter == '0);
  endfunction

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Handshake bundle between the control unit / streamer / engine side (master) and the scheduler (slave).
interface mac_job_scheduler_if
  import mac_package::*;
#(
  parameter int CNT_W = MAC_CNT_W
);

  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic [CNT_W-1:0] nb_iter_i;
  logic             simple_mul_i;
  logic             stream_ready_i;
  logic             engine_done_i;
  logic             store_done_i;

  logic             req_start_o;
  logic             engine_start_o;
  logic             engine_clear_o;
  logic [CNT_W-1:0] engine_len_o;
  logic             engine_simple_mul_o;
  logic [CNT_W-1:0] iter_idx_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, len_i, nb_iter_i, simple_mul_i,
    output stream_ready_i, engine_done_i, store_done_i,
    input  req_start_o, engine_start_o, engine_clear_o, engine_len_o,
    input  engine_simple_mul_o, iter_idx_o, busy_o, done_o
  );

  modport slave (
    input  start_i, len_i, nb_iter_i, simple_mul_i,
    input  stream_ready_i, engine_done_i, store_done_i,
    output req_start_o, engine_start_o, engine_clear_o, engine_len_o,
    output engine_simple_mul_o, iter_idx_o, busy_o, done_o
  );

endinterface

// File: rtl/mac_job_scheduler_counter.sv
// Iteration counter for the job scheduler; terminal count flags the last iteration of the job.
module mac_sched_counter
  import mac_package::*;
#(
  parameter int CNT_W = MAC_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] nb_iter_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Compare against nb_iter-1 rather than incrementing past it, so a full-range job never wraps.
  assign tc_o  = (cnt_q == (nb_iter_i - CNT_W'(1)));
  assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_job_scheduler.sv
// Job-level sequencer: turns one start pulse into nb_iter streamer/engine iterations and a done pulse.
module mac_job_scheduler
  import mac_package::*;
#(
  parameter int CNT_W = MAC_CNT_W
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                clear_i,
  mac_job_scheduler_if.slave bus
);

  sched_state_t     state_q, state_d;
  ctrl_sched_t      cfg_q, cfg_d;
  flags_sched_t     flags;
  logic             eng_seen_q, eng_seen_d;
  logic             st_seen_q, st_seen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eclr_q, eclr_d;
  logic             cnt_clear;
  logic             cnt_en;
  logic [CNT_W-1:0] iter_cnt;
  logic             iter_tc;
  logic             fire;

  // The streamer start is the only combinational output so an iteration launches the cycle ready rises.
  assign fire = (state_q == ARM) && bus.stream_ready_i;

  mac_sched_counter #(
    .CNT_W(CNT_W)
  ) u_iter_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (cnt_clear),
    .en_i     (cnt_en),
    .nb_iter_i(cfg_q.nb_iter),
    .cnt_o    (iter_cnt),
    .tc_o     (iter_tc)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    eng_seen_d = eng_seen_q;
    st_seen_d  = st_seen_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    eclr_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    if (clear_i) begin
      state_d    = IDLE;
      cfg_d      = '0;
      eng_seen_d = 1'b0;
      st_seen_d  = 1'b0;
      cnt_clear  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (job_is_empty(bus.len_i, bus.nb_iter_i)) begin
              done_d = 1'b1;
            end else begin
              cfg_d = '{len: bus.len_i, nb_iter: bus.nb_iter_i, simple_mul: bus.simple_mul_i};
              cnt_clear = 1'b1;
              state_d   = CLEAR;
            end
          end
        end
        CLEAR: state_d = ARM;
        ARM: begin
          if (fire) begin
            eng_seen_d = 1'b0;
            st_seen_d  = 1'b0;
            state_d    = RUN;
          end
        end
        RUN: begin
          // A store completion only counts once the engine result exists (same cycle or earlier).
          eng_seen_d = eng_seen_q | bus.engine_done_i;
          st_seen_d  = st_seen_q | (bus.store_done_i & eng_seen_d);
          if (eng_seen_d && st_seen_d) begin
            state_d = NEXT;
          end
        end
        NEXT: begin
          if (iter_tc) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_en  = 1'b1;
            state_d = ARM;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    eclr_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      eng_seen_q <= 1'b0;
      st_seen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eclr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      eng_seen_q <= eng_seen_d;
      st_seen_q  <= st_seen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      eclr_q     <= eclr_d;
    end
  end

  assign flags = '{busy: busy_q, done: done_q, iter_idx: iter_cnt};

  assign bus.req_start_o         = fire;
  assign bus.engine_start_o      = fire;
  assign bus.engine_clear_o      = eclr_q;
  assign bus.engine_len_o        = cfg_q.len;
  assign bus.engine_simple_mul_o = cfg_q.simple_mul;
  assign bus.iter_idx_o          = flags.iter_idx;
  assign bus.busy_o              = flags.busy;
  assign bus.done_o              = flags.done;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Self-checking bench for mac_job_scheduler: vector table, directed corner cases and random jobs vs. a job-level model.
module tb_mac_job_scheduler;
  import mac_package::*;

  localparam int CNT_W = MAC_CNT_W;

  logic clk_i;
  logic rst_ni;
  logic clear_i;

  mac_job_scheduler_if #(.CNT_W(CNT_W)) bus ();

  mac_job_scheduler #(.CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .bus    (bus)
  );

  typedef struct {
    int len;
    int nb;
    int el;
    int sl;
    int pre;
    int simple;
    int exp_req;
    int exp_clr;
    int exp_off;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int req_total = 0;
  int clr_total = 0;
  int done_total = 0;
  int busy_total = 0;
  int es_mis_total = 0;
  int last_done_cyc = -1;
  int last_store_cyc = -1;
  int iter_log[int];
  int len_log[int];
  int mode_log[int];
  int req_cyc_log[int];

  int eng_lat = 1;
  int st_lat = 1;
  int pre_lat = 0;
  int e_cnt = 0;
  int s_cnt = 0;
  int p_cnt = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Engine/store responder: pulses a fixed number of cycles after each streamer start.
  initial begin
    bus.engine_done_i = 1'b0;
    bus.store_done_i  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bus.req_start_o) begin
        e_cnt = eng_lat;
        s_cnt = st_lat;
        p_cnt = pre_lat;
      end
      @(posedge clk_i);
      #1;
      bus.engine_done_i = 1'b0;
      bus.store_done_i  = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) bus.engine_done_i = 1'b1;
      end
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) bus.store_done_i = 1'b1;
      end
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0) bus.store_done_i = 1'b1;
      end
    end
  end

  // Event monitor: running totals and logs sampled mid-cycle.
  initial forever begin
    @(negedge clk_i);
    if (bus.req_start_o) begin
      iter_log[req_total]    = int'(bus.iter_idx_o);
      len_log[req_total]     = int'(bus.engine_len_o);
      mode_log[req_total]    = int'(bus.engine_simple_mul_o);
      req_cyc_log[req_total] = cyc;
      req_total++;
    end
    if (bus.req_start_o != bus.engine_start_o) es_mis_total++;
    if (bus.engine_clear_o) clr_total++;
    if (bus.done_o) begin
      done_total++;
      last_done_cyc = cyc;
    end
    if (bus.busy_o) busy_total++;
    if (bus.store_done_i) last_store_cyc = cyc;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  // Job-level timing: each iteration costs the slower completion plus NEXT/ARM; DONE two cycles after the last.
  function automatic int model_done_offset(input int len, input int nb, input int el, input int sl);
    int lat;
    if (len == 0 || nb == 0) return 1;
    lat = (el > sl) ? el : sl;
    return nb * (lat + 2) + 2;
  endfunction

  task automatic start_pulse(input int len, input int nb, input int simple, output int s);
    tick();
    bus.start_i      = 1'b1;
    bus.len_i        = CNT_W'(len);
    bus.nb_iter_i    = CNT_W'(nb);
    bus.simple_mul_i = simple[0];
    s = cyc;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int db, input int limit);
    int n;
    n = 0;
    while (done_total == db && n < limit) begin
      sample();
      n++;
    end
  endtask

  task automatic apply_stimulus(input string tag, input int len, input int nb, input int el,
                                input int sl, input int pre, input int simple,
                                input int exp_req, input int exp_clr, input int exp_off);
    int rb, cb, db, bb, s;
    rb = req_total;
    cb = clr_total;
    db = done_total;
    bb = busy_total;
    eng_lat = el;
    st_lat  = sl;
    pre_lat = pre;
    start_pulse(len, nb, simple, s);
    wait_done(db, 400);
    repeat (3) sample();
    check_output({tag, "_done_cnt"}, done_total - db, 1);
    check_output({tag, "_done_off"}, last_done_cyc - s, exp_off);
    check_output({tag, "_req_cnt"}, req_total - rb, exp_req);
    check_output({tag, "_clr_cnt"}, clr_total - cb, exp_clr);
    check_output({tag, "_busy_cyc"}, busy_total - bb, (exp_req > 0) ? exp_off : 0);
    if (exp_req > 0 && req_total > rb) begin
      check_output({tag, "_store_to_done"}, last_done_cyc - last_store_cyc, 2);
      check_output({tag, "_eng_len"}, len_log[rb], len);
      check_output({tag, "_eng_mode"}, mode_log[rb], simple);
      for (int i = 0; i < exp_req; i++) begin
        if (req_total > rb + i) check_output({tag, "_iter_idx"}, iter_log[rb + i], i);
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    int s, rb, db, n;
    int len, nb, el, sl, pre, simple;

    vecs[0] = '{len: 8,     nb: 3, el: 10, sl: 10, pre: 0, simple: 0, exp_req: 3, exp_clr: 1, exp_off: 38};
    vecs[1] = '{len: 0,     nb: 5, el: 3,  sl: 3,  pre: 0, simple: 0, exp_req: 0, exp_clr: 0, exp_off: 1};
    vecs[2] = '{len: 5,     nb: 0, el: 3,  sl: 3,  pre: 0, simple: 1, exp_req: 0, exp_clr: 0, exp_off: 1};
    vecs[3] = '{len: 1,     nb: 1, el: 1,  sl: 1,  pre: 0, simple: 1, exp_req: 1, exp_clr: 1, exp_off: 5};
    vecs[4] = '{len: 3,     nb: 2, el: 2,  sl: 4,  pre: 0, simple: 0, exp_req: 2, exp_clr: 1, exp_off: 14};
    vecs[5] = '{len: 65535, nb: 2, el: 3,  sl: 3,  pre: 0, simple: 1, exp_req: 2, exp_clr: 1, exp_off: 12};
    vecs[6] = '{len: 4,     nb: 1, el: 4,  sl: 6,  pre: 2, simple: 0, exp_req: 1, exp_clr: 1, exp_off: 10};
    vecs[7] = '{len: 2,     nb: 2, el: 3,  sl: 3,  pre: 1, simple: 0, exp_req: 2, exp_clr: 1, exp_off: 12};

    rst_ni              = 1'b0;
    clear_i             = 1'b0;
    bus.start_i         = 1'b0;
    bus.len_i           = '0;
    bus.nb_iter_i       = '0;
    bus.simple_mul_i    = 1'b0;
    bus.stream_ready_i  = 1'b1;

    sample();
    check_output("rst_busy", int'(bus.busy_o), 0);
    check_output("rst_done", int'(bus.done_o), 0);
    check_output("rst_clear", int'(bus.engine_clear_o), 0);
    check_output("rst_req", int'(bus.req_start_o), 0);
    check_output("rst_eng_start", int'(bus.engine_start_o), 0);
    check_output("rst_iter", int'(bus.iter_idx_o), 0);
    check_output("rst_len", int'(bus.engine_len_o), 0);
    check_output("rst_mode", int'(bus.engine_simple_mul_o), 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].len, vecs[i].nb, vecs[i].el, vecs[i].sl,
                     vecs[i].pre, vecs[i].simple, vecs[i].exp_req, vecs[i].exp_clr, vecs[i].exp_off);
    end

    // Streamer backpressure: ready low for 20 ARM cycles, then the start fires on the first ready cycle.
    eng_lat = 2;
    st_lat  = 2;
    pre_lat = 0;
    bus.stream_ready_i = 1'b0;
    rb = req_total;
    db = done_total;
    start_pulse(2, 1, 0, s);
    n = 0;
    while (cyc < s + 21 && n < 100) begin
      sample();
      n++;
    end
    check_output("bp_no_req", req_total - rb, 0);
    check_output("bp_busy", int'(bus.busy_o), 1);
    tick();
    bus.stream_ready_i = 1'b1;
    sample();
    check_output("bp_req_cnt", req_total - rb, 1);
    check_output("bp_req_cyc", (req_total > rb) ? req_cyc_log[rb] - s : -1, 22);
    wait_done(db, 100);
    check_output("bp_done_off", last_done_cyc - s, 26);

    // Clear during iteration 2 of a 4-iteration job.
    eng_lat = 5;
    st_lat  = 5;
    rb = req_total;
    db = done_total;
    start_pulse(3, 4, 1, s);
    n = 0;
    while (req_total < rb + 3 && n < 200) begin
      sample();
      n++;
    end
    check_output("clr_iter_before", (req_total > rb + 2) ? iter_log[rb + 2] : -1, 2);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    sample();
    check_output("clr_busy", int'(bus.busy_o), 0);
    check_output("clr_iter", int'(bus.iter_idx_o), 0);
    check_output("clr_len", int'(bus.engine_len_o), 0);
    check_output("clr_mode", int'(bus.engine_simple_mul_o), 0);
    repeat (30) sample();
    check_output("clr_no_done", done_total - db, 0);
    check_output("clr_no_more_req", req_total - rb, 3);
    apply_stimulus("after_clr", 3, 4, 5, 5, 0, 0, 4, 1, 30);

    // Asynchronous reset while waiting in RUN.
    eng_lat = 6;
    st_lat  = 6;
    rb = req_total;
    db = done_total;
    start_pulse(2, 3, 1, s);
    n = 0;
    while (req_total < rb + 1 && n < 50) begin
      sample();
      n++;
    end
    sample();
    sample();
    #1;
    rst_ni = 1'b0;
    #1;
    check_output("arst_busy", int'(bus.busy_o), 0);
    check_output("arst_iter", int'(bus.iter_idx_o), 0);
    check_output("arst_len", int'(bus.engine_len_o), 0);
    tick();
    rst_ni = 1'b1;
    repeat (20) sample();
    check_output("arst_no_done", done_total - db, 0);
    check_output("arst_req_cnt", req_total - rb, 1);
    apply_stimulus("after_arst", 6, 2, 2, 3, 0, 1, 2, 1, 12);

    // Start while busy must not disturb the running job.
    eng_lat = 6;
    st_lat  = 6;
    rb = req_total;
    db = done_total;
    start_pulse(8, 2, 0, s);
    n = 0;
    while (req_total < rb + 1 && n < 50) begin
      sample();
      n++;
    end
    tick();
    bus.start_i   = 1'b1;
    bus.len_i     = CNT_W'(1);
    bus.nb_iter_i = CNT_W'(1);
    tick();
    bus.start_i = 1'b0;
    wait_done(db, 100);
    repeat (5) sample();
    check_output("busy_start_done_cnt", done_total - db, 1);
    check_output("busy_start_done_off", last_done_cyc - s, 18);
    check_output("busy_start_len", int'(bus.engine_len_o), 8);
    check_output("busy_start_len_it1", (req_total > rb + 1) ? len_log[rb + 1] : -1, 8);
    check_output("busy_start_req_cnt", req_total - rb, 2);

    // Random jobs against the job-level timing model.
    for (int j = 0; j < 12; j++) begin
      len    = $urandom_range(0, 20);
      nb     = $urandom_range(0, 5);
      el     = $urandom_range(1, 8);
      sl     = el + $urandom_range(0, 4);
      pre    = (el > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, el - 1) : 0;
      simple = $urandom_range(0, 1);
      apply_stimulus($sformatf("rnd%0d", j), len, nb, el, sl, pre, simple,
                     (len != 0 && nb != 0) ? nb : 0, (len != 0 && nb != 0) ? 1 : 0,
                     model_done_offset(len, nb, el, sl));
    end

    check_output("req_eq_engine_start", es_mis_total, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
